// File: rtl/dpe_if_skid_fifo.sv
// Circular-buffer skid FIFO for an AXI-Stream hop; first word falls through.
// Optional packet counter on pkt_cnt is enabled by defining DPE_IF_SKID_FIFO_STATS_EN.
module dpe_if_skid_fifo #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned USER_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]       s_axis_tkeep,
  input  logic                          s_axis_tlast,
  input  logic [USER_WIDTH-1:0]         s_axis_tuser,
  input  logic [ID_WIDTH-1:0]           s_axis_tid,

  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [ID_WIDTH-1:0]           m_axis_tid,

  output logic [$clog2(DEPTH):0]        level,
  output logic [31:0]                   pkt_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned KW = DATA_WIDTH / 8;
  localparam int unsigned PW = DATA_WIDTH + KW + 1 + USER_WIDTH + ID_WIDTH;
  localparam logic [AW:0] PtrOne = 1;

  logic [PW-1:0] mem [DEPTH];

  logic [AW:0] wp_q, wp_d;
  logic [AW:0] rp_q, rp_d;
  logic [AW:0] level_q, level_d;
  logic        full, empty, push, pop;

  // MSB is the wrap flag: equal low bits with differing wrap means full.
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty = (wp_q == rp_q);

  assign s_axis_tready = !full;
  assign m_axis_tvalid = !empty;

  assign push = s_axis_tvalid && !full;
  assign pop  = m_axis_tready && !empty;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    if (push) wp_d = wp_q + PtrOne;
    if (pop)  rp_d = rp_q + PtrOne;
    if (push && !pop) begin
      level_d = level_q + PtrOne;
    end else if (!push && pop) begin
      level_d = level_q - PtrOne;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
    end
  end

  // Storage is deliberately not reset; payload is only meaningful while tvalid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp_q[AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, s_axis_tid};
    end
  end

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tid} = mem[rp_q[AW-1:0]];
  assign level = level_q;

`ifdef DPE_IF_SKID_FIFO_STATS_EN
  logic [31:0] pkt_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_q <= '0;
    end else if (push && s_axis_tlast) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`else
  assign pkt_cnt = 32'd0;
`endif

endmodule

// File: doc/dpe_if_skid_fifo.md
DPE_IF_SKID_FIFO -- requirements
Module: dpe_if_skid_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, meaning the tdata width in bits; tkeep width is DATA_WIDTH/8.
REQ-002 SHALL have parameter USER_WIDTH, default 8, meaning the packed tuser width: {bypass_all, bypass_stage, src, dst}.
REQ-003 SHALL have parameter ID_WIDTH, default 8, meaning the tid width.
REQ-004 SHALL have parameter DEPTH, default 4, meaning the storage entries; legal values are powers of 2 from 2 to 16.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have slave ports s_axis_tvalid (in, 1), s_axis_tready (out, 1), s_axis_tdata (in, DATA_WIDTH), s_axis_tkeep (in, DATA_WIDTH/8), s_axis_tlast (in, 1), s_axis_tuser (in, USER_WIDTH) and s_axis_tid (in, ID_WIDTH).
REQ-008 SHALL have master ports m_axis_tvalid (out, 1), m_axis_tready (in, 1), m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser and m_axis_tid (out, widths as the matching slave ports).
REQ-009 SHALL have port level, output, $clog2(DEPTH)+1 bits: the current number of occupied entries.
REQ-010 SHALL have port pkt_cnt, output, 32 bits: the count of accepted tlast beats (see Configuration).

Function
REQ-011 SHALL be a circular buffer of DEPTH entries with write pointer wp and read pointer rp, each $clog2(DEPTH)+1 bits, where the MSB is the wrap flag.
REQ-012 SHALL define full as (wp[MSB] != rp[MSB]) && (wp[low] == rp[low]), and empty as wp == rp.
REQ-013 SHALL drive s_axis_tready = !full from registers only, with no combinational path from m_axis_tready.
REQ-014 SHALL complete a push on s_axis_tvalid && s_axis_tready, writing {tdata, tkeep, tlast, tuser, tid} at wp[low] and incrementing wp modulo 2*DEPTH.
REQ-015 SHALL drive m_axis_tvalid = !empty, with master payload read from entry rp[low]; the first word falls through.
REQ-016 SHALL give a latency of exactly 1 cycle from a push on edge N to m_axis_tvalid=1 after edge N, when the buffer was empty.
REQ-017 SHALL complete a pop on m_axis_tvalid && m_axis_tready, incrementing rp.
REQ-018 SHALL keep the master payload stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-019 SHALL, on a simultaneous push and pop, perform both in the same cycle with level unchanged.
REQ-020 SHALL, when full, not accept a push, even if a pop occurs in the same cycle; tready rises the cycle after the pop.
REQ-021 SHALL, when empty, not pop; m_axis_tready is ignored.
REQ-022 SHALL keep level = wp - rp modulo 2*DEPTH, registered and consistent with the pointers every cycle.
REQ-023 SHALL pass tlast, tuser and tid through unmodified; the block neither inspects nor reorders packets.
REQ-024 SHALL sustain full throughput of 1 beat per cycle indefinitely when m_axis_tready=1 constantly.

Reset
REQ-025 SHALL, while rst=0, asynchronously clear wp=0, rp=0, level=0 and pkt_cnt=0, so that s_axis_tready=1 and m_axis_tvalid=0.
REQ-026 SHALL NOT reset storage contents; master payload is don't-care while m_axis_tvalid=0.
REQ-027 SHALL discard all stored beats on a reset asserted mid-packet; the first beat after release is treated as new data.
REQ-028 SHALL accept the first push on the first rising edge after rst returns high.

Configuration
REQ-029 SHALL, with macro DPE_IF_SKID_FIFO_STATS_EN defined, implement pkt_cnt as a 32-bit counter that increments on every push with s_axis_tlast=1 and wraps 0xFFFF_FFFF -> 0.
REQ-030 SHALL, without DPE_IF_SKID_FIFO_STATS_EN, tie pkt_cnt to 0 and instantiate no counter logic.

Verification
REQ-031 SHALL cover: DEPTH=4, m_axis_tready=0, push 5 beats 0x1..0x5 -> 4 accepted, s_axis_tready=0 after the 4th, level=4.
REQ-032 SHALL cover: from that full state, m_axis_tready=1 -> beats 0x1..0x4 emerge in order; tready=1 one cycle after the first pop; beat 0x5 is then accepted.
REQ-033 SHALL cover: continuous push and pop of 1000 random beats with tready=1 -> zero bubbles, level constant at 1 after the first cycle, payload bit-exact.
REQ-034 SHALL cover: random tvalid/tready at 50% for 10k beats against a scoreboard -> in-order, lossless, and no payload change while stalled.
REQ-035 SHALL cover: 3-beat packet with tlast on beat 3, tuser=0xA5, tid=0x3C, then rst=0 mid-second-packet -> m_axis_tvalid=0 and level=0 immediately, and pkt_cnt=0 afterwards.
REQ-036 SHALL cover: with STATS_EN, 7 packets -> pkt_cnt=7; without STATS_EN -> pkt_cnt=0.
